// File: rtl/local_port_from_router_if.sv
// Router-to-local-device link bundle.
// Groups the receive side (flits in from the router, credits back to it) and
// the device side (valid/ready flit delivery plus the sticky error flag).
// Modports:
//   slave  - the local_port_from_router receiver
//   master - the environment (router transmit end and local device)
interface local_port_from_router_if #(
    parameter int FLIT_W   = 64,
    parameter int VC_IDX_W = 1
);
    logic                rx_flit_v_i;
    logic [VC_IDX_W-1:0] rx_flit_vc_id_i;
    logic [FLIT_W-1:0]   rx_flit_i;
    logic                rx_lcrd_v_o;
    logic [VC_IDX_W-1:0] rx_lcrd_id_o;
    logic                flit_v_o;
    logic [FLIT_W-1:0]   flit_o;
    logic [VC_IDX_W-1:0] flit_vc_id_o;
    logic                flit_rdy_i;
    logic                ovf_err_o;

    modport slave (
        input  rx_flit_v_i, rx_flit_vc_id_i, rx_flit_i, flit_rdy_i,
        output rx_lcrd_v_o, rx_lcrd_id_o, flit_v_o, flit_o, flit_vc_id_o, ovf_err_o
    );

    modport master (
        output rx_flit_v_i, rx_flit_vc_id_i, rx_flit_i, flit_rdy_i,
        input  rx_lcrd_v_o, rx_lcrd_id_o, flit_v_o, flit_o, flit_vc_id_o, ovf_err_o
    );
endinterface

// File: rtl/local_port_from_router.sv
// Local-device receiver for router-to-device traffic on a credit-based link.
// Incoming flits are buffered in per-VC FIFOs and presented to the device over
// valid/ready. Real-time VCs (0..RT_VC_NUM-1) win by fixed priority; common VCs
// share the output round-robin. Each dequeued flit returns one credit to the
// router one cycle later. Flits that overrun a VC or name a non-existent VC are
// dropped and latch ovf_err_o until reset.
// Ports:
//   clk  - rising-edge clock
//   rstn - asynchronous active-low reset
//   lp   - link bundle (slave modport): rx_flit_*, rx_lcrd_*, flit_*, ovf_err_o
module local_port_from_router #(
    parameter int VC_NUM    = 2,
    parameter int RT_VC_NUM = 0,
    parameter int VC_DEPTH  = 2,
    parameter int FLIT_W    = 64,
    parameter int VC_IDX_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    local_port_from_router_if.slave  lp
);
    localparam int PTR_W = (VC_DEPTH > 1) ? $clog2(VC_DEPTH) : 1;
    localparam int CNT_W = $clog2(VC_DEPTH + 1);

    // Advance a FIFO pointer modulo VC_DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(VC_DEPTH - 1)) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    logic [FLIT_W-1:0]   mem_r [VC_NUM][VC_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_r [VC_NUM];
    logic [PTR_W-1:0]    wr_ptr_r [VC_NUM];
    logic [CNT_W-1:0]    cnt_r [VC_NUM];
    logic [VC_IDX_W-1:0] rr_ptr_r;
    logic                flit_v_r;
    logic [VC_IDX_W-1:0] flit_vc_id_r;
    logic [FLIT_W-1:0]   flit_r;
    logic                lcrd_v_r;
    logic [VC_IDX_W-1:0] lcrd_id_r;
    logic                ovf_err_r;

    logic                deq_s;
    logic                hold_s;
    logic                vc_ok_s;
    logic                drop_s;
    logic [VC_NUM-1:0]   enq_s;
    logic [VC_NUM-1:0]   deq_hit_s;
    logic [CNT_W-1:0]    cnt_nxt_s [VC_NUM];
    logic [PTR_W-1:0]    rd_nxt_s [VC_NUM];
    logic [VC_IDX_W-1:0] rr_nxt_s;
    logic                sel_found_s;
    logic [VC_IDX_W-1:0] sel_vc_s;
    logic [FLIT_W-1:0]   head_s;
    int                  rr_idx_s;

    // Enqueue/dequeue decode and next-cycle occupancy per VC.
    always_comb begin
        deq_s   = flit_v_r & lp.flit_rdy_i;
        // A presented flit that is not taken is locked: outputs hold until the handshake.
        hold_s  = flit_v_r & ~lp.flit_rdy_i;
        vc_ok_s = int'(lp.rx_flit_vc_id_i) < VC_NUM;
        for (int v = 0; v < VC_NUM; v++) begin
            deq_hit_s[v] = deq_s & (flit_vc_id_r == VC_IDX_W'(v));
            // A full VC still accepts a flit when its head leaves in the same cycle.
            enq_s[v]     = lp.rx_flit_v_i & vc_ok_s & (lp.rx_flit_vc_id_i == VC_IDX_W'(v)) &
                           ((cnt_r[v] != CNT_W'(VC_DEPTH)) | deq_hit_s[v]);
            cnt_nxt_s[v] = cnt_r[v] + CNT_W'(enq_s[v]) - CNT_W'(deq_hit_s[v]);
            rd_nxt_s[v]  = deq_hit_s[v] ? ptr_inc(rd_ptr_r[v]) : rd_ptr_r[v];
        end
        drop_s = lp.rx_flit_v_i & ~(|enq_s);
    end

    // Round-robin pointer: moves past a dequeued common VC; RT grants leave it alone.
    always_comb begin
        if (deq_s && (int'(flit_vc_id_r) >= RT_VC_NUM)) begin
            rr_nxt_s = (int'(flit_vc_id_r) == VC_NUM - 1) ? VC_IDX_W'(RT_VC_NUM)
                                                          : flit_vc_id_r + VC_IDX_W'(1);
        end else begin
            rr_nxt_s = rr_ptr_r;
        end
    end

    // Pick the VC to present next cycle from the post-edge occupancy, so the
    // output registers carry the new head without a bubble.
    always_comb begin
        sel_found_s = 1'b0;
        sel_vc_s    = {VC_IDX_W{1'b0}};
        rr_idx_s    = 0;
        for (int v = 0; v < RT_VC_NUM; v++) begin
            if (!sel_found_s && (cnt_nxt_s[v] != {CNT_W{1'b0}})) begin
                sel_found_s = 1'b1;
                sel_vc_s    = VC_IDX_W'(v);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
        for (int k = 0; k < VC_NUM - RT_VC_NUM; k++) begin
            rr_idx_s = int'(rr_nxt_s) + k;
            rr_idx_s = (rr_idx_s >= VC_NUM) ? rr_idx_s - (VC_NUM - RT_VC_NUM) : rr_idx_s;
            if (!sel_found_s && (cnt_nxt_s[rr_idx_s] != {CNT_W{1'b0}})) begin
                sel_found_s = 1'b1;
                sel_vc_s    = VC_IDX_W'(rr_idx_s);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Next head payload; when the selected VC will hold only the flit being
    // written this cycle, take it straight from the input.
    always_comb begin
        if (!sel_found_s) begin
            head_s = {FLIT_W{1'b0}};
        end else if (enq_s[sel_vc_s] && (wr_ptr_r[sel_vc_s] == rd_nxt_s[sel_vc_s])) begin
            head_s = lp.rx_flit_i;
        end else begin
            head_s = mem_r[sel_vc_s][rd_nxt_s[sel_vc_s]];
        end
    end

    // FIFO storage (data path only, no reset needed).
    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++) begin
            if (enq_s[v]) begin
                mem_r[v][wr_ptr_r[v]] <= lp.rx_flit_i;
            end
        end
    end

    // Control state, output registers, credit return and sticky error.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int v = 0; v < VC_NUM; v++) begin
                rd_ptr_r[v] <= {PTR_W{1'b0}};
                wr_ptr_r[v] <= {PTR_W{1'b0}};
                cnt_r[v]    <= {CNT_W{1'b0}};
            end
            rr_ptr_r     <= VC_IDX_W'(RT_VC_NUM);
            flit_v_r     <= 1'b0;
            flit_vc_id_r <= {VC_IDX_W{1'b0}};
            flit_r       <= {FLIT_W{1'b0}};
            lcrd_v_r     <= 1'b0;
            lcrd_id_r    <= {VC_IDX_W{1'b0}};
            ovf_err_r    <= 1'b0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (enq_s[v]) begin
                    wr_ptr_r[v] <= ptr_inc(wr_ptr_r[v]);
                end
                rd_ptr_r[v] <= rd_nxt_s[v];
                cnt_r[v]    <= cnt_nxt_s[v];
            end
            rr_ptr_r <= rr_nxt_s;
            lcrd_v_r <= deq_s;
            if (deq_s) begin
                lcrd_id_r <= flit_vc_id_r;
            end
            if (drop_s) begin
                ovf_err_r <= 1'b1;
            end
            if (!hold_s) begin
                flit_v_r     <= sel_found_s;
                flit_vc_id_r <= sel_vc_s;
                flit_r       <= head_s;
            end
        end
    end

    assign lp.flit_v_o     = flit_v_r;
    assign lp.flit_vc_id_o = flit_vc_id_r;
    assign lp.flit_o       = flit_r;
    assign lp.rx_lcrd_v_o  = lcrd_v_r;
    assign lp.rx_lcrd_id_o = lcrd_id_r;
    assign lp.ovf_err_o    = ovf_err_r;
endmodule

// File: tb/tb_local_port_from_router.sv
// Bench for local_port_from_router (VC_NUM=3, RT_VC_NUM=1, VC_DEPTH=2).
// A queue-per-VC reference model predicts the outputs every cycle; directed
// scenarios are followed by a randomized phase with a mid-run reset.
module tb_local_port_from_router;
    localparam int VC_NUM    = 3;
    localparam int RT_VC_NUM = 1;
    localparam int VC_DEPTH  = 2;
    localparam int FLIT_W    = 64;
    localparam int VC_IDX_W  = 2;
    localparam int NC        = VC_NUM - RT_VC_NUM;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    local_port_from_router_if #(.FLIT_W(FLIT_W), .VC_IDX_W(VC_IDX_W)) lp ();

    local_port_from_router #(
        .VC_NUM(VC_NUM), .RT_VC_NUM(RT_VC_NUM), .VC_DEPTH(VC_DEPTH),
        .FLIT_W(FLIT_W), .VC_IDX_W(VC_IDX_W)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .lp(lp)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [FLIT_W-1:0] q [VC_NUM][$];
    bit m_locked;
    int m_lock_vc;
    int m_rr;
    bit m_cred_v;
    int m_cred_id;
    bit m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int v = 0; v < VC_NUM; v++) q[v].delete();
        m_locked  = 1'b0;
        m_lock_vc = 0;
        m_rr      = RT_VC_NUM;
        m_cred_v  = 1'b0;
        m_cred_id = 0;
        m_err     = 1'b0;
    endfunction

    // Which VC the device should currently see.
    function automatic void present(output bit pv, output int pvc);
        pv  = 1'b0;
        pvc = 0;
        if (m_locked) begin
            pv  = 1'b1;
            pvc = m_lock_vc;
        end else begin
            for (int i = 0; i < RT_VC_NUM; i++)
                if (!pv && q[i].size() > 0) begin pv = 1'b1; pvc = i; end
            for (int k = 0; k < NC; k++) begin
                int c;
                c = RT_VC_NUM + (m_rr - RT_VC_NUM + k) % NC;
                if (!pv && q[c].size() > 0) begin pv = 1'b1; pvc = c; end
            end
        end
    endfunction

    // Advance the model across one clock edge with the given inputs.
    function automatic void model_step(input bit v, input int vc, input logic [FLIT_W-1:0] d, input bit rdy);
        bit pv;
        int pvc;
        present(pv, pvc);
        if (pv && rdy) begin
            void'(q[pvc].pop_front());
            m_cred_v  = 1'b1;
            m_cred_id = pvc;
            if (pvc >= RT_VC_NUM) m_rr = RT_VC_NUM + (pvc - RT_VC_NUM + 1) % NC;
            m_locked  = 1'b0;
        end else begin
            m_cred_v  = 1'b0;
            m_locked  = pv;
            m_lock_vc = pvc;
        end
        if (v) begin
            if (vc >= VC_NUM)                 m_err = 1'b1;
            else if (q[vc].size() >= VC_DEPTH) m_err = 1'b1;
            else                              q[vc].push_back(d);
        end
    endfunction

    task automatic check_outputs(input string tag);
        bit pv;
        int pvc;
        present(pv, pvc);
        chk({tag, ".flit_v"}, 64'(lp.flit_v_o), 64'(pv));
        if (pv) begin
            chk({tag, ".flit_vc"}, 64'(lp.flit_vc_id_o), 64'(pvc));
            chk({tag, ".flit_data"}, lp.flit_o, q[pvc][0]);
        end
        chk({tag, ".lcrd_v"}, 64'(lp.rx_lcrd_v_o), 64'(m_cred_v));
        chk({tag, ".lcrd_id"}, 64'(lp.rx_lcrd_id_o), 64'(m_cred_id));
        chk({tag, ".ovf_err"}, 64'(lp.ovf_err_o), 64'(m_err));
    endtask

    task automatic cycle(input bit v, input int vc, input logic [FLIT_W-1:0] d, input bit rdy, input string tag);
        lp.rx_flit_v_i     = v;
        lp.rx_flit_vc_id_i = VC_IDX_W'(vc);
        lp.rx_flit_i       = d;
        lp.flit_rdy_i      = rdy;
        model_step(v, vc, d, rdy);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        lp.rx_flit_v_i = 1'b0;
        lp.flit_rdy_i  = 1'b0;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rstn = 1'b1;
    endtask

    initial begin
        int vcs [4];
        lp.rx_flit_v_i     = 1'b0;
        lp.rx_flit_vc_id_i = '0;
        lp.rx_flit_i       = '0;
        lp.flit_rdy_i      = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset.flit_vc_id", 64'(lp.flit_vc_id_o), 64'd0);
        rstn = 1'b1;

        // Single flit: visible one cycle after enqueue, credit one cycle after dequeue.
        cycle(1'b1, 1, 64'hA5, 1'b1, "single0");
        chk("single.data", lp.flit_o, 64'hA5);
        chk("single.vc", 64'(lp.flit_vc_id_o), 64'd1);
        cycle(1'b0, 0, 64'h0, 1'b1, "single1");
        chk("single.lcrd_v", 64'(lp.rx_lcrd_v_o), 64'd1);
        chk("single.lcrd_id", 64'(lp.rx_lcrd_id_o), 64'd1);
        chk("single.empty", 64'(lp.flit_v_o), 64'd0);

        // Lock: a later RT flit must not preempt a stalled common VC.
        do_reset();
        cycle(1'b1, 2, 64'hC2, 1'b0, "lock0");
        cycle(1'b1, 0, 64'hB0, 1'b0, "lock1");
        chk("lock.held_vc", 64'(lp.flit_vc_id_o), 64'd2);
        chk("lock.held_data", lp.flit_o, 64'hC2);
        cycle(1'b0, 0, 64'h0, 1'b1, "lock2");
        chk("lock.rt_next", 64'(lp.flit_vc_id_o), 64'd0);
        cycle(1'b0, 0, 64'h0, 1'b1, "lock3");
        chk("lock.lcrd0", 64'(lp.rx_lcrd_id_o), 64'd0);
        cycle(1'b0, 0, 64'h0, 1'b1, "lock4");

        // Round robin across common VCs 1 and 2.
        do_reset();
        cycle(1'b1, 1, 64'h11, 1'b0, "rr_fill0");
        cycle(1'b1, 1, 64'h12, 1'b0, "rr_fill1");
        cycle(1'b1, 2, 64'h21, 1'b0, "rr_fill2");
        cycle(1'b1, 2, 64'h22, 1'b0, "rr_fill3");
        vcs = '{1, 2, 1, 2};
        for (int i = 0; i < 4; i++) begin
            chk("rr.seq", 64'(lp.flit_vc_id_o), 64'(vcs[i]));
            cycle(1'b0, 0, 64'h0, 1'b1, "rr_drain");
            chk("rr.credit", 64'(lp.rx_lcrd_id_o), 64'(vcs[i]));
        end
        cycle(1'b0, 0, 64'h0, 1'b1, "rr_idle");

        // Full FIFO overrun drops the flit and latches the error.
        do_reset();
        cycle(1'b1, 0, 64'hF1, 1'b0, "full0");
        cycle(1'b1, 0, 64'hF2, 1'b0, "full1");
        chk("full.no_err", 64'(lp.ovf_err_o), 64'd0);
        cycle(1'b1, 0, 64'hF3, 1'b0, "full2");
        chk("full.err", 64'(lp.ovf_err_o), 64'd1);
        repeat (3) cycle(1'b0, 0, 64'h0, 1'b1, "full_drain");
        chk("full.drained", 64'(lp.flit_v_o), 64'd0);

        // Full VC with simultaneous dequeue and enqueue: accepted, no error.
        do_reset();
        cycle(1'b1, 0, 64'hD1, 1'b0, "sim0");
        cycle(1'b1, 0, 64'hD2, 1'b0, "sim1");
        cycle(1'b1, 0, 64'hD3, 1'b1, "sim2");
        chk("sim.no_err", 64'(lp.ovf_err_o), 64'd0);
        repeat (3) cycle(1'b0, 0, 64'h0, 1'b1, "sim_drain");

        // Out-of-range VC index is dropped and flagged.
        do_reset();
        cycle(1'b1, 3, 64'hEE, 1'b1, "badvc");
        chk("badvc.err", 64'(lp.ovf_err_o), 64'd1);
        chk("badvc.none", 64'(lp.flit_v_o), 64'd0);

        // Reset mid-operation with 3 flits buffered and a credit pending.
        do_reset();
        cycle(1'b1, 1, 64'h31, 1'b0, "mid0");
        cycle(1'b1, 1, 64'h32, 1'b0, "mid1");
        cycle(1'b1, 2, 64'h33, 1'b0, "mid2");
        cycle(1'b1, 2, 64'h34, 1'b0, "mid3");
        cycle(1'b0, 0, 64'h0, 1'b1, "mid4");
        lp.flit_rdy_i = 1'b0;
        #1 rstn = 1'b0;
        #1;
        chk("mid.flit_v", 64'(lp.flit_v_o), 64'd0);
        chk("mid.flit_vc", 64'(lp.flit_vc_id_o), 64'd0);
        chk("mid.lcrd_v", 64'(lp.rx_lcrd_v_o), 64'd0);
        chk("mid.lcrd_id", 64'(lp.rx_lcrd_id_o), 64'd0);
        model_reset();
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (3) cycle(1'b0, 0, 64'h0, 1'b1, "mid_idle");
        cycle(1'b1, 2, 64'h55, 1'b1, "mid_new");

        // Randomized traffic, mostly within credits, with a reset halfway.
        for (int i = 0; i < 600; i++) begin
            bit v;
            int vc;
            if (i == 300) do_reset();
            v  = ($urandom_range(0, 99) < 60);
            vc = ($urandom_range(0, 199) == 0) ? 3 : int'($urandom_range(0, VC_NUM - 1));
            if (vc < VC_NUM && q[vc].size() >= VC_DEPTH && $urandom_range(0, 19) != 0) v = 1'b0;
            cycle(v, vc, {$urandom, $urandom}, ($urandom_range(0, 99) < 65), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
